// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Parses 5-byte command frames (HEADER, OP, A, B, CHK) from a
//             UART byte stream, launches one ALU operation per good frame,
//             captures the ALU result and reports framing/timeout errors.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : system clock, rising edge
//    rst          : asynchronous reset, active low
//    rx_data      : received byte, valid while rx_valid is high
//    rx_valid     : one-cycle byte strobe
//    alu_op/a/b   : registered ALU operation and operands
//    alu_start    : one-cycle ALU launch pulse
//    alu_done     : ALU completion strobe
//    alu_result   : ALU result, valid with alu_done
//    alu_flags    : ALU flags {N,Z,C,V}, valid with alu_done
//    result_out   : last captured ALU result
//    flags_out    : last captured ALU flags
//    result_valid : one-cycle pulse when result_out/flags_out update
//    err          : one-cycle error pulse
//    err_code     : cause of latest err (00 opcode, 01 checksum,
//                   10 byte timeout, 11 ALU timeout), held until next err
//    busy         : high whenever the sequencer is not idle
// ============================================================================
module alu_cmd_sequencer #(
    parameter int         BYTE_TIMEOUT = 520833,
    parameter int         ALU_TIMEOUT  = 16,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] result_out,
    output logic [3:0] flags_out,
    output logic       result_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    // Timers count 0 .. TIMEOUT-1; expiry is the cycle in which the last
    // permitted count is reached without the awaited event.
    localparam int c_BT_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int c_WT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

    localparam logic [c_BT_W-1:0] c_BT_LAST = c_BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [c_BT_W-1:0] c_BT_ONE  = c_BT_W'(1);
    localparam logic [c_WT_W-1:0] c_WT_LAST = c_WT_W'(ALU_TIMEOUT - 1);
    localparam logic [c_WT_W-1:0] c_WT_ONE  = c_WT_W'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_GET_OP  = 3'd1;
    localparam logic [2:0] c_GET_A   = 3'd2;
    localparam logic [2:0] c_GET_B   = 3'd3;
    localparam logic [2:0] c_GET_CHK = 3'd4;
    localparam logic [2:0] c_EXEC    = 3'd5;
    localparam logic [2:0] c_WAIT    = 3'd6;

    localparam logic [1:0] c_ERR_OPCODE   = 2'b00;
    localparam logic [1:0] c_ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] c_ERR_BYTE_TMO = 2'b10;
    localparam logic [1:0] c_ERR_ALU_TMO  = 2'b11;

    logic [2:0]        r_state;
    logic [c_BT_W-1:0] r_byte_tmr;
    logic [c_WT_W-1:0] r_wait_tmr;

    // Frame fields are staged here so that a bad checksum leaves the
    // ALU-facing operand registers untouched.
    logic [3:0] r_op_buf;
    logic [7:0] r_a_buf;
    logic [7:0] r_b_buf;

    logic [3:0] r_alu_op;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic       r_alu_start;
    logic [7:0] r_result_out;
    logic [3:0] r_flags_out;
    logic       r_result_valid;
    logic       r_err;
    logic [1:0] r_err_code;
    logic       r_busy;

    logic w_chk_ok;
    logic w_byte_expired;
    logic w_wait_expired;

    assign w_chk_ok       = (rx_data == ({4'h0, r_op_buf} ^ r_a_buf ^ r_b_buf));
    assign w_byte_expired = (r_byte_tmr == c_BT_LAST);
    assign w_wait_expired = (r_wait_tmr == c_WT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_IDLE;
            r_byte_tmr     <= '0;
            r_wait_tmr     <= '0;
            r_op_buf       <= '0;
            r_a_buf        <= '0;
            r_b_buf        <= '0;
            r_alu_op       <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_start    <= 1'b0;
            r_result_out   <= '0;
            r_flags_out    <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= '0;
            r_busy         <= 1'b0;
        end else begin
            // Pulse outputs default low; each branch raises at most one.
            r_alu_start    <= 1'b0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_byte_tmr <= '0;
                    if (rx_valid && (rx_data == HEADER)) begin
                        r_state <= c_GET_OP;
                        r_busy  <= 1'b1;
                    end
                end

                c_GET_OP, c_GET_A, c_GET_B, c_GET_CHK: begin
                    // Expiry is checked first so a byte landing in the
                    // expiry cycle is dropped.
                    if (w_byte_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_BYTE_TMO;
                        r_state    <= c_IDLE;
                        r_busy     <= 1'b0;
                        r_byte_tmr <= '0;
                    end else if (rx_valid) begin
                        r_byte_tmr <= '0;
                        case (r_state)
                            c_GET_OP: begin
                                if (rx_data[7:4] != 4'h0) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= c_ERR_OPCODE;
                                    r_state    <= c_IDLE;
                                    r_busy     <= 1'b0;
                                end else begin
                                    r_op_buf <= rx_data[3:0];
                                    r_state  <= c_GET_A;
                                end
                            end
                            c_GET_A: begin
                                r_a_buf <= rx_data;
                                r_state <= c_GET_B;
                            end
                            c_GET_B: begin
                                r_b_buf <= rx_data;
                                r_state <= c_GET_CHK;
                            end
                            c_GET_CHK: begin
                                if (w_chk_ok) begin
                                    r_alu_op    <= r_op_buf;
                                    r_alu_a     <= r_a_buf;
                                    r_alu_b     <= r_b_buf;
                                    r_alu_start <= 1'b1;
                                    r_state     <= c_EXEC;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= c_ERR_CHECKSUM;
                                    r_state    <= c_IDLE;
                                    r_busy     <= 1'b0;
                                end
                            end
                            default: begin
                                r_state <= c_IDLE;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_byte_tmr <= r_byte_tmr + c_BT_ONE;
                    end
                end

                // alu_start is high during this cycle; alu_done is not
                // looked at until WAIT.
                c_EXEC: begin
                    r_wait_tmr <= '0;
                    r_state    <= c_WAIT;
                end

                c_WAIT: begin
                    if (alu_done) begin
                        r_result_out   <= alu_result;
                        r_flags_out    <= alu_flags;
                        r_result_valid <= 1'b1;
                        r_state        <= c_IDLE;
                        r_busy         <= 1'b0;
                    end else if (w_wait_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_ALU_TMO;
                        r_state    <= c_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_wait_tmr <= r_wait_tmr + c_WT_ONE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_op       = r_alu_op;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_start    = r_alu_start;
    assign result_out   = r_result_out;
    assign flags_out    = r_flags_out;
    assign result_valid = r_result_valid;
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Purpose  : Directed self-checking bench for alu_cmd_sequencer using
//             hand-computed frames and expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int BT = 40;
    localparam int AT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_flags = 4'h0;
    logic [7:0] result_out;
    logic [3:0] flags_out;
    logic       result_valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_rv     = 0;
    int n_err    = 0;
    int n_both   = 0;
    int n;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .BYTE_TIMEOUT(BT),
        .ALU_TIMEOUT (AT),
        .HEADER      (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .result_out  (result_out),
        .flags_out   (flags_out),
        .result_valid(result_valid),
        .err         (err),
        .err_code    (err_code),
        .busy        (busy)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (alu_start)           n_start++;
        if (result_valid)        n_rv++;
        if (err)                 n_err++;
        if (err && result_valid) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one cycle; returns 1ns after the
    // edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_alu_op",   alu_op,     0);
        check_eq("rst_alu_a",    alu_a,      0);
        check_eq("rst_result",   result_out, 0);
        check_eq("rst_err_code", err_code,   0);
        check_eq("rst_busy",     busy,       0);
        rst = 1'b1;

        // ---------------- good frame A5 03 12 34 25 ----------------
        send_byte(8'hA5);
        check_eq("hdr_busy", busy, 1);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h25);
        check_eq("t1_start", alu_start, 1);
        check_eq("t1_op",    alu_op,    4'h3);
        check_eq("t1_a",     alu_a,     8'h12);
        check_eq("t1_b",     alu_b,     8'h34);
        // done during EXEC must be ignored
        alu_done = 1'b1; alu_result = 8'hFF; alu_flags = 4'hF;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_eq("t1_start_off", alu_start,    0);
        check_eq("t1_exec_done", result_valid, 0);
        check_eq("t1_wait_busy", busy,         1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        alu_done = 1'b1; alu_result = 8'h46; alu_flags = 4'h0;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_eq("t1_rv",     result_valid, 1);
        check_eq("t1_result", result_out,   8'h46);
        check_eq("t1_flags",  flags_out,    4'h0);
        check_eq("t1_busy",   busy,         0);
        @(posedge clk); #1;
        check_eq("t1_rv_off", result_valid, 0);

        // ---------------- bad checksum A5 05 77 11 64 (good = 63) ----------------
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h77);
        send_byte(8'h11);
        send_byte(8'h64);
        check_eq("t2_err",   err,       1);
        check_eq("t2_code",  err_code,  2'b01);
        check_eq("t2_start", alu_start, 0);
        check_eq("t2_op",    alu_op,    4'h3);
        check_eq("t2_a",     alu_a,     8'h12);
        check_eq("t2_b",     alu_b,     8'h34);
        check_eq("t2_busy",  busy,      0);

        // ---------------- junk then bad opcode ----------------
        send_byte(8'h00);
        check_eq("t3_00_err",  err,  0);
        check_eq("t3_00_busy", busy, 0);
        send_byte(8'h7F);
        check_eq("t3_7f_err",  err,  0);
        check_eq("t3_7f_busy", busy, 0);
        send_byte(8'hA5);
        check_eq("t3_hdr_busy", busy, 1);
        send_byte(8'h13);
        check_eq("t3_err",  err,      1);
        check_eq("t3_code", err_code, 2'b00);
        check_eq("t3_busy", busy,     0);

        // ---------------- byte timeout ----------------
        send_byte(8'hA5);
        send_byte(8'h01);
        n = 0;
        while (!err && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t4_tmo_cycles", n,        BT);
        check_eq("t4_code",       err_code, 2'b10);
        check_eq("t4_busy",       busy,     0);

        // byte arriving in the expiry cycle is dropped
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (BT - 1) @(posedge clk);
        #1;
        rx_data = 8'h20; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check_eq("t4p_err",  err,      1);
        check_eq("t4p_code", err_code, 2'b10);
        check_eq("t4p_busy", busy,     0);

        // next frame A5 02 10 03 11 completes normally
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        check_eq("t4f_start", alu_start, 1);
        check_eq("t4f_op",    alu_op,    4'h2);
        @(posedge clk); #1;
        alu_done = 1'b1; alu_result = 8'h0D; alu_flags = 4'h1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_eq("t4f_rv",     result_valid, 1);
        check_eq("t4f_result", result_out,   8'h0D);
        check_eq("t4f_flags",  flags_out,    4'h1);

        // ---------------- ALU timeout, header during WAIT ----------------
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h07);
        check_eq("t5_start", alu_start, 1);
        n = 0;
        while (!err && n < 100) begin
            if (n == 3) begin
                rx_data  = 8'hA5;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        rx_valid = 1'b0;
        // one EXEC cycle plus ALU_TIMEOUT WAIT cycles
        check_eq("t5_tmo_cycles", n,          AT + 1);
        check_eq("t5_code",       err_code,   2'b11);
        check_eq("t5_busy",       busy,       0);
        check_eq("t5_result",     result_out, 8'h0D);
        @(posedge clk); #1;
        check_eq("t5_busy_after", busy, 0);

        // ---------------- reset during GET_B ----------------
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        check_eq("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #2;
        check_eq("t6_busy",     busy,       0);
        check_eq("t6_op",       alu_op,     0);
        check_eq("t6_a",        alu_a,      0);
        check_eq("t6_b",        alu_b,      0);
        check_eq("t6_result",   result_out, 0);
        check_eq("t6_flags",    flags_out,  0);
        check_eq("t6_err_code", err_code,   0);
        check_eq("t6_err",      err,        0);
        @(posedge clk); #1;
        rst = 1'b1;
        alu_done = 1'b1; alu_result = 8'h99;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_eq("t6_late_done_rv", result_valid, 0);
        check_eq("t6_late_result",  result_out,   0);
        send_byte(8'h03);
        check_eq("t6_idle_busy", busy, 0);
        send_byte(8'hA5);
        check_eq("t6_hdr_busy", busy, 1);

        // ---------------- pulse totals ----------------
        @(posedge clk); #1;
        check_eq("cnt_start", n_start, 3);
        check_eq("cnt_rv",    n_rv,    2);
        check_eq("cnt_err",   n_err,   5);
        check_eq("cnt_both",  n_both,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
